// File: rtl/snd_mix_pkg.sv
// Shared types and constants for the time-multiplexed sound mixer.
package snd_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_e;

  localparam logic [7:0] GAIN_UNITY = 8'h10;
  localparam logic [4:0] VOL_MAX    = 5'd16;

  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/snd_mix_peak.sv
// Clip indicator: a clip reloads the hold counter, PEAK stays high until it drains.
module snd_mix_peak #(
  parameter int HW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clip,
  input  logic [HW-1:0] hold,
  output logic          peak
);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          peak_q, peak_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clip) begin
      cnt_d = hold;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    peak_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      peak_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/snd_mix_seq.sv
// N-channel mixer: one shared multiplier accumulates channel*gain per pass,
// then master-volume scaling with a soft-mute ramp and output saturation.
module snd_mix_seq
  import snd_mix_pkg::*;
#(
  parameter int          CH        = 4,
  parameter int          W         = 16,
  parameter int          WOUT      = 16,
  parameter logic [19:0] PEAK_HOLD = 20'hFFFFF
) (
  input  logic                   CLK96,
  input  logic                   RESET96_N,
  input  logic                   CEN,
  input  logic [CH*W-1:0]        CH_IN,
  input  logic [CH*8-1:0]        GAIN,
  input  logic                   MUTE,
  output logic signed [WOUT-1:0] MIXED,
  output logic                   SAMPLE,
  output logic                   PEAK,
  output logic                   BUSY
);

  localparam int IW = clog2_w(CH);
  localparam int PW = W + 9;
  localparam int AW = W + 9 + clog2_w(CH);
  localparam int SW = AW + 6;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  state_e                 state_q, state_d;
  logic [CH*W-1:0]        ch_q, ch_d;
  logic [CH*8-1:0]        gain_q, gain_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4:0]             vol_q, vol_d;
  logic signed [WOUT-1:0] mixed_q, mixed_d;
  logic                   sample_q, sample_d;
  logic                   busy_q, busy_d;
  logic                   clip;

  logic signed [W-1:0]    ch_sel;
  logic [7:0]             gain_sel;
  logic signed [PW-1:0]   prod;
  logic signed [SW-1:0]   mix_full;
  logic signed [SW-1:0]   scaled;

  assign ch_sel   = ch_q[int'(idx_q)*W +: W];
  assign gain_sel = gain_q[int'(idx_q)*8 +: 8];
  assign prod     = ch_sel * $signed({1'b0, gain_sel});

  // Gain and volume both carry 4 fractional bits, hence the shift by 8.
  assign mix_full = $signed({{(SW-AW){acc_q[AW-1]}}, acc_q}) *
                    $signed({{(SW-5){1'b0}}, vol_q});
  assign scaled   = mix_full >>> 8;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    gain_d   = gain_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    vol_d    = vol_q;
    mixed_d  = mixed_q;
    sample_d = 1'b0;
    busy_d   = (state_q != ST_IDLE);
    clip     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CEN) begin
          ch_d    = CH_IN;
          gain_d  = GAIN;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + $signed({{(AW-PW){prod[PW-1]}}, prod});
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(CH-1)) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (scaled > SAT_MAX) begin
          mixed_d = {1'b0, {(WOUT-1){1'b1}}};
          clip    = 1'b1;
        end else if (scaled < SAT_MIN) begin
          mixed_d = {1'b1, {(WOUT-1){1'b0}}};
          clip    = 1'b1;
        end else begin
          mixed_d = scaled[WOUT-1:0];
        end
        sample_d = 1'b1;
        // Volume used this pass first, stepped for the next one.
        if (MUTE && vol_q != 5'd0)      vol_d = vol_q - 5'd1;
        else if (!MUTE && vol_q < VOL_MAX) vol_d = vol_q + 5'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      gain_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      vol_q    <= VOL_MAX;
      mixed_q  <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      gain_q   <= gain_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      vol_q    <= vol_d;
      mixed_q  <= mixed_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
    end
  end

  snd_mix_peak #(.HW(20)) u_peak (
    .clk   (CLK96),
    .rst_n (RESET96_N),
    .clip  (clip),
    .hold  (PEAK_HOLD),
    .peak  (PEAK)
  );

  assign MIXED  = mixed_q;
  assign SAMPLE = sample_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_snd_mix_seq.sv
// Scoreboard bench for snd_mix_seq: stimulus pushes predicted samples, a monitor pops on SAMPLE.
module tb_snd_mix_seq;

  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int WOUT = 16;
  localparam int HOLD = 100;

  logic                   CLK96 = 1'b0;
  logic                   RESET96_N = 1'b0;
  logic                   CEN = 1'b0;
  logic                   MUTE = 1'b0;
  logic [CH*W-1:0]        CH_IN = '0;
  logic [CH*8-1:0]        GAIN = '0;
  logic signed [WOUT-1:0] MIXED;
  logic                   SAMPLE, PEAK, BUSY;

  snd_mix_seq #(.CH(CH), .W(W), .WOUT(WOUT), .PEAK_HOLD(20'd100)) dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .CEN(CEN), .CH_IN(CH_IN),
    .GAIN(GAIN), .MUTE(MUTE), .MIXED(MIXED), .SAMPLE(SAMPLE),
    .PEAK(PEAK), .BUSY(BUSY)
  );

  always #5 CLK96 = ~CLK96;

  int unsigned cyc = 0;
  always @(posedge CLK96) cyc <= cyc + 1;

  typedef struct { int mixed; bit clip; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_samples = 0;
  int m_vol = 16;
  int chv[CH];
  int gv[CH];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: sum of products, times volume/256 with floor rounding, then clamp.
  function automatic exp_t predict();
    longint sum, p, q;
    exp_t e;
    sum = 0;
    for (int i = 0; i < CH; i++) sum += longint'(chv[i]) * longint'(gv[i]);
    p = sum * m_vol;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    e.clip  = (q > 32767) || (q < -32768);
    e.mixed = (q > 32767) ? 32767 : (q < -32768) ? -32768 : int'(q);
    if (MUTE && m_vol > 0) m_vol--;
    else if (!MUTE && m_vol < 16) m_vol++;
    return e;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < CH; i++) begin
      CH_IN[i*W +: W] = chv[i][W-1:0];
      GAIN[i*8 +: 8]  = gv[i][7:0];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK96);
    #1;
  endtask

  // Returns just after the accept edge (edge 0).
  task automatic start_pass();
    apply_inputs();
    CEN = 1'b1;
    @(posedge CLK96);
    #1;
    CEN = 1'b0;
    sb.push_back(predict());
  endtask

  task automatic run_pass(input int gap);
    start_pass();
    idle(gap - 1);
  endtask

  task automatic set_stim(input int c0, input int c1, input int c2, input int c3, input int g);
    chv[0] = c0; chv[1] = c1; chv[2] = c2; chv[3] = c3;
    for (int i = 0; i < CH; i++) gv[i] = g;
  endtask

  task automatic wait_sample(input string name);
    int k;
    k = 0;
    @(negedge CLK96);
    while (!SAMPLE && k < 20) begin
      k++;
      @(negedge CLK96);
    end
    if (!SAMPLE) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic measure_peak(input string name);
    int count;
    count = 0;
    while (PEAK && count < 300) begin
      count++;
      @(negedge CLK96);
    end
    check(name, count, HOLD);
  endtask

  // Monitor
  int unsigned last_clip = 0;
  bit lc_valid = 1'b0;
  always @(negedge CLK96) begin
    exp_t e;
    bit exp_peak;
    if (!RESET96_N) begin
      lc_valid = 1'b0;
    end else if (SAMPLE) begin
      n_samples++;
      if (sb.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        e = sb.pop_front();
        exp_peak = e.clip || (lc_valid && (cyc - last_clip) < HOLD);
        if (e.clip) begin
          lc_valid  = 1'b1;
          last_clip = cyc;
        end
        check($sformatf("mixed@%0d", cyc), MIXED, e.mixed);
        check($sformatf("peak@%0d", cyc), PEAK, exp_peak);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    // Reset state
    RESET96_N = 1'b0;
    repeat (3) @(posedge CLK96);
    @(negedge CLK96);
    check("rst_mixed", MIXED, 0);
    check("rst_sample", SAMPLE, 0);
    check("rst_peak", PEAK, 0);
    check("rst_busy", BUSY, 0);
    RESET96_N = 1'b1;
    idle(2);

    // Unity single channel with cycle-exact BUSY/SAMPLE timing
    set_stim(1000, 0, 0, 0, 16);
    s0 = n_samples;
    start_pass();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(posedge CLK96);
      @(negedge CLK96);
      check($sformatf("busy_e%0d", k), BUSY, (k <= 5) ? 1 : 0);
      check($sformatf("sample_e%0d", k), SAMPLE, (k == 5) ? 1 : 0);
    end
    check("unity_sample_count", n_samples - s0, 1);
    idle(2);

    // Fractional gains
    set_stim(1000, 0, 0, 0, 16); gv[0] = 8'h08; run_pass(8);
    gv[0] = 8'h18; run_pass(8);
    chv[0] = -1000; gv[0] = 8'h08; run_pass(8);

    // Positive clip and hold duration
    set_stim(20000, 20000, 20000, 20000, 16);
    start_pass();
    wait_sample("clip_pos");
    measure_peak("peak_hold_pos");
    idle(2);

    // Negative clip, then a second clip ~50 cycles later extends the hold
    set_stim(-32768, -32768, 0, 0, 16);
    start_pass();
    wait_sample("clip_neg");
    idle(44);
    start_pass();
    wait_sample("clip_neg2");
    measure_peak("peak_hold_ext");
    idle(2);

    // Soft mute ramp down then back up
    set_stim(1600, 0, 0, 0, 16);
    MUTE = 1'b1;
    for (int i = 0; i < 18; i++) run_pass(10);
    MUTE = 1'b0;
    for (int i = 0; i < 17; i++) run_pass(10);
    check("vol_restored_model", m_vol, 16);

    // CEN while busy is dropped; CEN at edge 6 starts a new pass
    set_stim(1234, -567, 89, 3000, 16);
    gv[2] = 8'h30;
    s0 = n_samples;
    start_pass();
    idle(2);
    CEN = 1'b1; @(posedge CLK96); #1; CEN = 1'b0;
    idle(1);
    CEN = 1'b1; @(posedge CLK96); #1; CEN = 1'b0;
    set_stim(-2000, 700, 0, 50, 8'h10);
    start_pass();
    idle(14);
    check("busy_ignore_samples", n_samples - s0, 2);

    // Snapshot: inputs changed mid-pass do not disturb the result
    set_stim(4000, -3000, 2500, 100, 8'h14);
    start_pass();
    idle(1);
    CH_IN = 64'h7FFF_7FFF_7FFF_7FFF;
    GAIN  = 32'hFFFF_FFFF;
    idle(8);

    // Reset mid-pass after lowering volume and raising PEAK
    set_stim(20000, 20000, 20000, 20000, 16);
    MUTE = 1'b1;
    for (int i = 0; i < 3; i++) run_pass(8);
    MUTE = 1'b0;
    set_stim(1000, 0, 0, 0, 16);
    apply_inputs();
    CEN = 1'b1; @(posedge CLK96); #1; CEN = 1'b0;
    idle(2);
    s0 = n_samples;
    RESET96_N = 1'b0;
    #1;
    check("midrst_mixed", MIXED, 0);
    check("midrst_sample", SAMPLE, 0);
    check("midrst_peak", PEAK, 0);
    check("midrst_busy", BUSY, 0);
    m_vol = 16;
    idle(3);
    RESET96_N = 1'b1;
    idle(10);
    check("midrst_no_sample", n_samples - s0, 0);
    run_pass(8);

    // Randomized passes
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < CH; i++) begin
        chv[i] = int'($urandom_range(0, 65535)) - 32768;
        gv[i]  = int'($urandom_range(0, 255));
      end
      MUTE = ($urandom_range(0, 3) == 0);
      run_pass(6 + int'($urandom_range(0, 3)));
    end
    MUTE = 1'b0;

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge CLK96);
    #1;
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
